// File: rtl/alu_mdu.sv
// alu_mdu: handshaked execute-stage ALU with registered result, flags and iterative mul/div.
// Define ALU_MDU_DIV_EN to build the restoring divider; without it DIVU/DIV return 0 with ovf set.
module alu_mdu #(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned SHAMT_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [4:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] r,
    output logic [WIDTH-1:0] r_hi,
    output logic             zero,
    output logic             neg,
    output logic             carry,
    output logic             ovf,
    output logic             busy
);

    typedef enum logic [1:0] {StIdle, StBusy, StFix, StHold} state_e;

    state_e             state_q;
    logic [SHAMT_W-1:0] cnt_q;
    logic               sa_q, sb_q;
    logic [WIDTH-1:0]   ma_q, acc_hi_q, acc_lo_q;

    logic               accept, is_iter, sgn_a, sgn_b;
    logic [WIDTH-1:0]   mag_a, mag_b;
    logic [WIDTH:0]     sum, dif;
    logic [WIDTH-1:0]   alu_r;
    logic               alu_c, alu_v;
    logic [SHAMT_W-1:0] sh;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH-1:0]   step_hi, step_lo;
    logic [2*WIDTH-1:0] prod, prod_fix;
    logic [WIDTH-1:0]   fix_r, fix_hi;
    logic               fix_v;
`ifdef ALU_MDU_DIV_EN
    logic               div_q;
    logic [WIDTH-1:0]   mb_q, a_q;
    logic [WIDTH:0]     div_sh;
    logic               div_ge;
`endif

    assign in_ready = (state_q == StIdle) | ((state_q == StHold) & out_ready);
    assign busy     = (state_q == StBusy) | (state_q == StFix);
    assign accept   = in_valid & in_ready;
    assign sh       = a[SHAMT_W-1:0];
    assign sgn_a    = op[0] & a[WIDTH-1];
    assign sgn_b    = op[0] & b[WIDTH-1];
    assign mag_a    = sgn_a ? -a : a;
    assign mag_b    = sgn_b ? -b : b;
`ifdef ALU_MDU_DIV_EN
    assign is_iter  = op[4] & (op[3:2] == 2'b00);
`else
    assign is_iter  = op[4] & (op[3:1] == 3'b000);
`endif

    // Single-cycle datapath; unused op[4] codes fall through as ADDU.
    always_comb begin
        sum   = {1'b0, a} + {1'b0, b};
        dif   = {1'b0, a} - {1'b0, b};
        alu_r = sum[WIDTH-1:0];
        alu_c = sum[WIDTH];
        alu_v = 1'b0;
        if (!op[4]) begin
            case (op[3:0])
                4'b0000: alu_v = 1'b0;
                4'b0010: alu_v = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
                4'b0001: begin alu_r = dif[WIDTH-1:0]; alu_c = dif[WIDTH]; end
                4'b0011: begin
                    alu_r = dif[WIDTH-1:0];
                    alu_c = dif[WIDTH];
                    alu_v = (a[WIDTH-1] != b[WIDTH-1]) && (dif[WIDTH-1] != a[WIDTH-1]);
                end
                4'b0100: begin alu_r = a & b;          alu_c = 1'b0; end
                4'b0101: begin alu_r = a | b;          alu_c = 1'b0; end
                4'b0110: begin alu_r = a ^ b;          alu_c = 1'b0; end
                4'b0111: begin alu_r = ~(a | b);       alu_c = 1'b0; end
                4'b1000,
                4'b1001: begin alu_r = b << (WIDTH/2); alu_c = 1'b0; end
                4'b1010: begin alu_r = {{(WIDTH-1){1'b0}}, a < b}; alu_c = 1'b0; end
                4'b1011: begin
                    alu_r = {{(WIDTH-1){1'b0}}, $signed(a) < $signed(b)};
                    alu_c = 1'b0;
                end
                4'b1100: begin alu_r = $signed(b) >>> sh; alu_c = 1'b0; end
                4'b1101: begin alu_r = b >> sh;           alu_c = 1'b0; end
                default: begin alu_r = b << sh;           alu_c = 1'b0; end
            endcase
        end
`ifndef ALU_MDU_DIV_EN
        else if (op[3:1] == 3'b001) begin
            alu_r = '0;
            alu_c = 1'b0;
            alu_v = 1'b1;
        end
`endif
    end

    // One iteration: shift-add multiply, or restoring divide with acc_hi as remainder.
    always_comb begin
        mul_sum            = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, ma_q} : '0);
        {step_hi, step_lo} = {mul_sum, acc_lo_q[WIDTH-1:1]};
`ifdef ALU_MDU_DIV_EN
        div_sh = {acc_hi_q, acc_lo_q[WIDTH-1]};
        div_ge = div_sh >= {1'b0, mb_q};
        if (div_q) begin
            step_hi = div_ge ? div_sh[WIDTH-1:0] - mb_q : div_sh[WIDTH-1:0];
            step_lo = {acc_lo_q[WIDTH-2:0], div_ge};
        end
`endif
    end

    always_comb begin
        prod     = {acc_hi_q, acc_lo_q};
        prod_fix = (sa_q ^ sb_q) ? -prod : prod;
        fix_r    = prod_fix[WIDTH-1:0];
        fix_hi   = prod_fix[2*WIDTH-1:WIDTH];
        fix_v    = 1'b0;
`ifdef ALU_MDU_DIV_EN
        if (div_q) begin
            if (mb_q == '0) begin
                fix_r  = '1;
                fix_hi = a_q;
            end else begin
                fix_r  = (sa_q ^ sb_q) ? -acc_lo_q : acc_lo_q;
                fix_hi = sa_q ? -acc_hi_q : acc_hi_q;
                fix_v  = sb_q & (mb_q == WIDTH'(1)) & (a_q == {1'b1, {(WIDTH-1){1'b0}}});
            end
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            out_valid <= 1'b0;
            r         <= '0;
            r_hi      <= '0;
            zero      <= 1'b0;
            neg       <= 1'b0;
            carry     <= 1'b0;
            ovf       <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle, StHold: begin
                    if (state_q == StHold && out_ready) begin
                        out_valid <= 1'b0;
                        state_q   <= StIdle;
                    end
                    if (accept) begin
                        if (is_iter) begin
                            state_q   <= StBusy;
                            out_valid <= 1'b0;
                            cnt_q     <= '0;
                            sa_q      <= sgn_a;
                            sb_q      <= sgn_b;
                            ma_q      <= mag_a;
                            acc_hi_q  <= '0;
                            acc_lo_q  <= mag_b;
`ifdef ALU_MDU_DIV_EN
                            div_q     <= op[1];
                            mb_q      <= mag_b;
                            a_q       <= a;
                            if (op[1]) acc_lo_q <= mag_a;
`endif
                        end else begin
                            state_q   <= StHold;
                            out_valid <= 1'b1;
                            r         <= alu_r;
                            r_hi      <= '0;
                            zero      <= (alu_r == '0);
                            neg       <= alu_r[WIDTH-1];
                            carry     <= alu_c;
                            ovf       <= alu_v;
                        end
                    end
                end
                StBusy: begin
                    acc_hi_q <= step_hi;
                    acc_lo_q <= step_lo;
                    cnt_q    <= cnt_q + SHAMT_W'(1);
                    if (cnt_q == SHAMT_W'(WIDTH - 1)) state_q <= StFix;
                end
                StFix: begin
                    state_q   <= StHold;
                    out_valid <= 1'b1;
                    r         <= fix_r;
                    r_hi      <= fix_hi;
                    zero      <= (fix_r == '0);
                    neg       <= fix_r[WIDTH-1];
                    carry     <= 1'b0;
                    ovf       <= fix_v;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_mdu.sv
// tb_alu_mdu: directed literal checks plus randomized traffic against an arithmetic reference model.
// Honours ALU_MDU_DIV_EN the same way as the design.
module tb_alu_mdu;

    localparam int W = 32;
    localparam longint SMAX = 64'sh7FFF_FFFF;
    localparam longint SMIN = -SMAX - 1;

    typedef struct packed {
        logic [31:0] r;
        logic [31:0] rhi;
        logic        z, n, c, v, iter;
        int          lat;
        int          ready;
    } exp_t;

    logic        clk, rst, in_valid, in_ready, out_valid, out_ready;
    logic [4:0]  op;
    logic [31:0] a, b, r, r_hi;
    logic        zero, neg, carry, ovf, busy;

    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    bit   armed = 0;
    exp_t q[$];
    logic exp_valid, exp_busy, exp_rdy;

    alu_mdu #(.WIDTH(32), .SHAMT_W(5)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .op(op), .a(a), .b(b),
        .out_valid(out_valid), .out_ready(out_ready), .r(r), .r_hi(r_hi), .zero(zero),
        .neg(neg), .carry(carry), .ovf(ovf), .busy(busy)
    );

    initial clk = 0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", name, cyc, got, exp);
        end
    endtask

    function automatic exp_t model(input logic [4:0] o, input logic [31:0] x, input logic [31:0] y);
        exp_t e;
        longint unsigned ux, uy;
        longint sx, sy, t;
        logic [63:0] p;
        int sh;
        ux = {32'd0, x};
        uy = {32'd0, y};
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        sh = int'(ux % 32);
        e = '0;
        e.lat = 1;
        if (o[4] && o[3:1] == 3'b000) begin
            if (o[0]) t = sx * sy; else t = longint'(ux * uy);
            p = t;
            e.r = p[31:0]; e.rhi = p[63:32]; e.iter = 1; e.lat = W + 2;
        end else if (o[4] && o[3:1] == 3'b001) begin
`ifdef ALU_MDU_DIV_EN
            e.iter = 1; e.lat = W + 2;
            if (y == 0) begin
                e.r = '1; e.rhi = x;
            end else if (o[0] && x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin
                e.r = x; e.rhi = 0; e.v = 1;
            end else if (o[0]) begin
                t = sx / sy; p = t; e.r = p[31:0];
                t = sx % sy; p = t; e.rhi = p[31:0];
            end else begin
                e.r = 32'(ux / uy); e.rhi = 32'(ux % uy);
            end
`else
            e.v = 1;
`endif
        end else if (o[4]) begin
            p = ux + uy; e.r = p[31:0]; e.c = p[32];
        end else begin
            case (o[3:0])
                4'b0000, 4'b0010: begin
                    p = ux + uy; e.r = p[31:0]; e.c = p[32];
                    t = sx + sy;
                    if (o[1]) e.v = (t > SMAX) || (t < SMIN);
                end
                4'b0001, 4'b0011: begin
                    e.r = x - y; e.c = ux < uy;
                    t = sx - sy;
                    if (o[1]) e.v = (t > SMAX) || (t < SMIN);
                end
                4'b0100: e.r = x & y;
                4'b0101: e.r = x | y;
                4'b0110: e.r = x ^ y;
                4'b0111: e.r = ~(x | y);
                4'b1000, 4'b1001: e.r = 32'(uy * 65536);
                4'b1010: e.r = (ux < uy) ? 1 : 0;
                4'b1011: e.r = (sx < sy) ? 1 : 0;
                4'b1100: e.r = 32'(sy >>> sh);
                4'b1101: e.r = 32'(uy >> sh);
                default: e.r = 32'(uy << sh);
            endcase
        end
        e.z = (e.r == 0);
        e.n = e.r[31];
        return e;
    endfunction

    // Compare process: the model tracks the one operation in flight and when it must appear.
    always @(negedge clk) begin
        exp_valid = q.size() > 0 && cyc >= q[0].ready;
        exp_busy  = q.size() > 0 && q[0].iter && cyc < q[0].ready;
        exp_rdy   = q.size() == 0 || (exp_valid && out_ready);
        if (armed) begin
            chk("mon_out_valid", out_valid, exp_valid);
            chk("mon_in_ready", in_ready, exp_rdy);
            chk("mon_busy", busy, exp_busy);
            if (exp_valid) begin
                chk("mon_r", r, q[0].r);
                chk("mon_r_hi", r_hi, q[0].rhi);
                chk("mon_flags", {zero, neg, carry, ovf}, {q[0].z, q[0].n, q[0].c, q[0].v});
            end
        end
        if (rst) begin
            q.delete();
            armed = 1;
        end else if (armed) begin
            if (exp_valid && out_ready) void'(q.pop_front());
            if (in_valid && exp_rdy) begin
                exp_t e;
                e = model(op, a, b);
                e.ready = cyc + e.lat;
                q.push_back(e);
            end
        end
    end

    task automatic issue(input logic [4:0] o, input logic [31:0] x, input logic [31:0] y,
                         output int acc);
        bit ok = 0;
        @(posedge clk); #1;
        in_valid = 1; op = o; a = x; b = y;
        acc = cyc;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (in_ready) begin ok = 1; acc = cyc; break; end
        end
        if (!ok) begin
            checks++; failures++;
            $display("FAIL issue_timeout cyc=%0d in_ready=%b", cyc, in_ready);
        end
        @(posedge clk); #1;
        in_valid = 0; a = $urandom; b = $urandom; op = 5'(($urandom));
    endtask

    task automatic wait_out(input int acc, input bit chk_busy, output int lat);
        bit ok = 0;
        lat = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (out_valid) begin ok = 1; break; end
            if (chk_busy) begin
                chk("iter_in_ready_low", in_ready, 0);
                chk("iter_busy_high", busy, 1);
            end
        end
        lat = cyc - acc;
        if (!ok) begin
            checks++; failures++;
            $display("FAIL result_timeout cyc=%0d out_valid=%b", cyc, out_valid);
        end
    endtask

    function automatic logic [31:0] pick_val();
        case ($urandom % 8)
            0: return 32'h0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'h7FFF_FFFF;
            4: return 32'($urandom % 16) - 32'd8;
            default: return $urandom;
        endcase
    endfunction

    function automatic logic [4:0] pick_op();
        int s;
        s = int'($urandom % 20);
        if (s < 14) return {1'b0, 4'($urandom)};
        else if (s < 19) return {3'b100, 2'($urandom)};
        else return {1'b1, 4'($urandom)};
    endfunction

    exp_t        e;
    int          acc, lat;
    logic [31:0] held, va[4], vb[4];

    initial begin
        rst = 1; in_valid = 0; op = 0; a = 0; b = 0; out_ready = 1;

        // Pin the reference model to hand-derived values.
        e = model(5'b10001, 32'hFFFF_FFFD, 32'd7);
        chk("pin_mult", {e.rhi, e.r}, 64'hFFFF_FFFF_FFFF_FFEB);
        e = model(5'b01100, 32'd36, 32'h8000_0000);
        chk("pin_sra", e.r, 32'hF800_0000);
        e = model(5'b00010, 32'h7FFF_FFFF, 32'd1);
        chk("pin_add_ovf", {e.v, e.n, e.c}, 3'b110);
        e = model(5'b00001, 32'd3, 32'd5);
        chk("pin_subu", {e.c, e.r}, {1'b1, 32'hFFFF_FFFE});

        repeat (2) @(posedge clk);
        #1 rst = 0;
        @(negedge clk);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_r", {r, r_hi}, 64'd0);
        chk("rst_flags", {zero, neg, carry, ovf, busy}, 5'd0);
        chk("rst_in_ready", in_ready, 1);

        issue(5'b00000, 32'hFFFF_FFFF, 32'd1, acc);
        wait_out(acc, 0, lat);
        chk("addu_lat", lat, 1);
        chk("addu_r", r, 0);
        chk("addu_flags", {zero, carry, ovf}, 3'b110);

        issue(5'b00010, 32'h7FFF_FFFF, 32'd1, acc);
        wait_out(acc, 0, lat);
        chk("add_r", r, 32'h8000_0000);
        chk("add_flags", {ovf, neg}, 2'b11);

        issue(5'b01100, 32'd36, 32'h8000_0000, acc);
        wait_out(acc, 0, lat);
        chk("sra_r", r, 32'hF800_0000);

        issue(5'b10001, 32'hFFFF_FFFD, 32'd7, acc);
        wait_out(acc, 1, lat);
        chk("mult_lat", lat, 34);
        chk("mult_prod", {r_hi, r}, 64'hFFFF_FFFF_FFFF_FFEB);

`ifdef ALU_MDU_DIV_EN
        issue(5'b10011, 32'hFFFF_FFF9, 32'd2, acc);
        wait_out(acc, 1, lat);
        chk("div_lat", lat, 34);
        chk("div_q_rem", {r, r_hi}, {32'hFFFF_FFFD, 32'hFFFF_FFFF});
        issue(5'b10010, 32'd5, 32'd0, acc);
        wait_out(acc, 0, lat);
        chk("divu_by_zero", {r, r_hi}, {32'hFFFF_FFFF, 32'd5});
        issue(5'b10011, 32'h8000_0000, 32'hFFFF_FFFF, acc);
        wait_out(acc, 0, lat);
        chk("div_ovf", {r, r_hi, ovf}, {32'h8000_0000, 32'd0, 1'b1});
`else
        issue(5'b10010, 32'd5, 32'd3, acc);
        wait_out(acc, 0, lat);
        chk("divu_off_lat", lat, 1);
        chk("divu_off", {r, r_hi, ovf}, {32'd0, 32'd0, 1'b1});
`endif

        // Hold a result, then stream ANDs back to back.
        @(posedge clk); #1 out_ready = 0;
        issue(5'b00110, 32'h1234_5678, 32'h0F0F_F0F0, acc);
        wait_out(acc, 0, lat);
        held = r;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("hold_r", r, held);
            chk("hold_in_ready", in_ready, 0);
            chk("hold_valid", out_valid, 1);
        end
        va = '{32'hFFFF_0000, 32'h1234_5678, 32'hAAAA_AAAA, 32'h0000_00FF};
        vb = '{32'h0F0F_0F0F, 32'hFFFF_0000, 32'h5555_FFFF, 32'hFFFF_FFFF};
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            out_ready = 1; in_valid = 1; op = 5'b00100; a = va[i]; b = vb[i];
            @(negedge clk);
            chk("stream_in_ready", in_ready, 1);
            if (i > 0) begin
                chk("stream_valid", out_valid, 1);
                chk("stream_r", r, va[i-1] & vb[i-1]);
            end
        end
        @(posedge clk); #1 in_valid = 0;
        @(negedge clk);
        chk("stream_valid", out_valid, 1);
        chk("stream_r", r, va[3] & vb[3]);

        // Abort a multiply mid-iteration.
        issue(5'b10000, 32'd123456, 32'd789, acc);
        repeat (10) @(posedge clk);
        #1 rst = 1;
        @(posedge clk); #1 rst = 0;
        @(negedge clk);
        chk("abort_state", {out_valid, busy, in_ready}, 3'b001);
        issue(5'b00001, 32'd3, 32'd5, acc);
        wait_out(acc, 0, lat);
        chk("subu_r", r, 32'hFFFF_FFFE);
        chk("subu_carry", carry, 1);

        for (int i = 0; i < 4000; i++) begin
            @(posedge clk); #1;
            rst       = ($urandom % 600) == 0;
            in_valid  = rst ? 1'b0 : (($urandom % 4) != 0);
            op        = pick_op();
            a         = pick_val();
            b         = pick_val();
            out_ready = ($urandom % 3) != 0;
        end
        @(posedge clk); #1;
        rst = 0; in_valid = 0; out_ready = 1;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (!out_valid && !busy) break;
        end
        chk("final_idle", {out_valid, busy, in_ready}, 3'b001);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
